// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard and interrupt-entry sequencer for the 8-bit core.
//
// Drives the hold and flush controls for PC, IF/ID, ID/EX and EX/MEM from
// three sources:
//   - load-use hazards between the instruction in ID and a load in EX,
//   - taken branches resolved in EX,
//   - interrupt entry (drain, push PC, push flags, load vector).
// Control outputs are combinational from the registered state and the
// current inputs, so the pipeline registers act on a hazard at the same edge.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   id_rs, id_rt             source registers of the instruction in ID
//   id_uses_rs, id_uses_rt   ID instruction actually reads rs / rt
//   ex_rd                    destination register of the instruction in EX
//   ex_reg_write             EX instruction writes a register
//   ex_mem_read              EX instruction is a load/pop
//   ex_branch_taken          branch/jump resolved taken in EX
//   intr_req                 level-sensitive interrupt request
//   pc_write                 PC updates this cycle
//   if_id_write              IF/ID captures new data
//   if_id_flush              IF/ID loads a bubble
//   id_ex_flush              ID/EX loads a bubble
//   ex_mem_flush             EX/MEM loads a bubble
//   int_phase                0 none, 1 push PC, 2 push flags, 3 load vector
//   int_ack                  one-cycle pulse when the vector is loaded
//   busy                     interrupt sequence in progress
//   stall_cnt                saturating count of load-use stall cycles
module pipeline_hazard_ctrl #(
  parameter int unsigned INT_DRAIN_CYCLES = 2,
  parameter int unsigned STALL_CNT_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             id_rs,
  input  logic [1:0]             id_rt,
  input  logic                   id_uses_rs,
  input  logic                   id_uses_rt,
  input  logic [1:0]             ex_rd,
  input  logic                   ex_reg_write,
  input  logic                   ex_mem_read,
  input  logic                   ex_branch_taken,
  input  logic                   intr_req,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   ex_mem_flush,
  output logic [1:0]             int_phase,
  output logic                   int_ack,
  output logic                   busy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [2:0] {
    StRun,
    StDrain,
    StPushPc,
    StPushFlags,
    StVector
  } state_e;

  // drain_cnt counts down to zero, so it is loaded with one less than the
  // number of drain cycles.
  localparam logic [2:0] DrainInit = 3'(INT_DRAIN_CYCLES - 1);

  state_e                 state_q;
  logic [2:0]             drain_cnt_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  logic lu;
  logic lu_eff;

  assign lu = ex_mem_read & ex_reg_write &
              ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

  // A taken branch flushes the dependent instruction anyway, so the stall is moot.
  assign lu_eff = lu & ~ex_branch_taken;

  assign stall_cnt = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      drain_cnt_q <= 3'd0;
      stall_cnt_q <= '0;
    end else begin
      // Stalls are only exposed to the pipe in RUN and DRAIN.
      if (lu_eff && (state_q == StRun || state_q == StDrain) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end

      unique case (state_q)
        StRun: begin
          if (intr_req && !ex_branch_taken && !lu) begin
            state_q     <= StDrain;
            drain_cnt_q <= DrainInit;
          end
        end
        StDrain: begin
          if (!lu_eff) begin
            if (drain_cnt_q == 3'd0) begin
              state_q <= StPushPc;
            end else begin
              drain_cnt_q <= drain_cnt_q - 3'd1;
            end
          end
        end
        StPushPc:    state_q <= StPushFlags;
        StPushFlags: state_q <= StVector;
        StVector:    state_q <= StRun;
        default:     state_q <= StRun;
      endcase
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    int_phase    = 2'd0;
    int_ack      = 1'b0;
    busy         = 1'b0;

    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else begin
      unique case (state_q)
        StRun: begin
          if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (lu) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
        StDrain: begin
          busy = 1'b1;
          // PC holds the return address; a taken branch redirects it to the target.
          pc_write = ex_branch_taken;
          if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (lu) begin
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end else begin
            if_id_flush = 1'b1;
          end
        end
        StPushPc: begin
          busy        = 1'b1;
          int_phase   = 2'd1;
          pc_write    = 1'b0;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
        StPushFlags: begin
          busy        = 1'b1;
          int_phase   = 2'd2;
          pc_write    = 1'b0;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
        StVector: begin
          busy        = 1'b1;
          int_phase   = 2'd3;
          int_ack     = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
        default: begin
          pc_write = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int unsigned DRAIN = 2;
  localparam int unsigned SW    = 8;
  localparam int          SMAX  = 255;

  logic          clk;
  logic          rst;
  logic [1:0]    id_rs, id_rt, ex_rd;
  logic          id_uses_rs, id_uses_rt, ex_reg_write, ex_mem_read;
  logic          ex_branch_taken, intr_req;
  logic          pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0]    int_phase;
  logic          int_ack, busy;
  logic [SW-1:0] stall_cnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: cycles of drain left (0 = not draining), current
  // interrupt phase (0 = none), and stall count as a plain integer.
  int m_drain = 0;
  int m_phase = 0;
  int m_stall = 0;

  pipeline_hazard_ctrl #(
    .INT_DRAIN_CYCLES(DRAIN),
    .STALL_CNT_W     (SW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_uses_rs     (id_uses_rs),
    .id_uses_rt     (id_uses_rt),
    .ex_rd          (ex_rd),
    .ex_reg_write   (ex_reg_write),
    .ex_mem_read    (ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .intr_req       (intr_req),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .ex_mem_flush   (ex_mem_flush),
    .int_phase      (int_phase),
    .int_ack        (int_ack),
    .busy           (busy),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_in(input logic [1:0] rs_v, input logic [1:0] rt_v, input logic urs_v,
                        input logic urt_v, input logic [1:0] rd_v, input logic rw_v,
                        input logic mr_v, input logic br_v, input logic intr_v,
                        input logic rst_v);
    id_rs = rs_v; id_rt = rt_v; id_uses_rs = urs_v; id_uses_rt = urt_v; ex_rd = rd_v;
    ex_reg_write = rw_v; ex_mem_read = mr_v; ex_branch_taken = br_v; intr_req = intr_v;
    rst = rst_v;
  endtask

  task automatic set_idle(input logic intr_v);
    set_in(2'd0, 2'd1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0, intr_v, 1'b0);
  endtask

  task automatic set_lu(input logic intr_v);
    set_in(2'd2, 2'd0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, intr_v, 1'b0);
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic model_lu();
    return ex_mem_read && ex_reg_write &&
           ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
  endfunction

  // Wait for the falling edge and compare all outputs with the model.
  task automatic sample();
    logic lu, br;
    logic e_pc, e_ifw, e_iff, e_idf, e_emf, e_ack, e_busy, c_ifw, c_stall;
    logic [1:0] e_ph;
    logic [16:0] a, e, m;
    @(negedge clk);
    lu = model_lu();
    br = ex_branch_taken;
    e_pc = 1; e_ifw = 1; e_iff = 0; e_idf = 0; e_emf = 0; e_ph = 0; e_ack = 0; e_busy = 0;
    c_ifw = 1; c_stall = 1;
    if (rst) begin
      e_pc = 0; e_ifw = 0; e_iff = 1; e_idf = 1; e_emf = 1;
      c_stall = 0;
    end else if (m_drain > 0) begin
      e_busy = 1;
      e_pc = br;
      if (br) begin
        e_iff = 1; e_idf = 1; c_ifw = 0;
      end else if (lu) begin
        e_ifw = 0; e_idf = 1;
      end else begin
        e_iff = 1; c_ifw = 0;
      end
    end else if (m_phase > 0) begin
      e_busy = 1; e_ph = 2'(m_phase); e_pc = (m_phase == 3); e_ack = (m_phase == 3);
      e_iff = 1; e_idf = 1; c_ifw = 0;
    end else if (br) begin
      e_iff = 1; e_idf = 1; c_ifw = 0;
    end else if (lu) begin
      e_pc = 0; e_ifw = 0; e_idf = 1;
    end
    a = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, int_phase, int_ack,
         busy, stall_cnt};
    e = {e_pc, e_ifw, e_iff, e_idf, e_emf, e_ph, e_ack, e_busy, 8'(m_stall)};
    m = {1'b1, c_ifw, 7'h7f, {8{c_stall}}};
    checks++;
    if (((a ^ e) & m) !== 17'd0) begin
      errors++;
      $display("FAIL model cycle %0d: got %h want %h (mask %h)", cyc, a, e, m);
    end
  endtask

  // Advance the model across the coming edge, then move to just after it.
  task automatic advance();
    logic lu_eff;
    lu_eff = model_lu() && !ex_branch_taken;
    if (rst) begin
      m_drain = 0; m_phase = 0; m_stall = 0;
    end else if (m_drain > 0) begin
      if (lu_eff) begin
        if (m_stall < SMAX) m_stall++;
      end else if (m_drain == 1) begin
        m_drain = 0; m_phase = 1;
      end else begin
        m_drain--;
      end
    end else if (m_phase > 0) begin
      m_phase = (m_phase == 3) ? 0 : m_phase + 1;
    end else if (!ex_branch_taken) begin
      if (lu_eff) begin
        if (m_stall < SMAX) m_stall++;
      end else if (intr_req) begin
        m_drain = DRAIN;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  typedef struct {
    string      name;
    logic [1:0] rs, rt, rd;
    logic       urs, urt, rw, mr, br;
    logic       ifw_care;
    logic [4:0] exp;  // {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush}
  } vec_t;

  vec_t vecs[10];

  initial begin
    int ack_at, acks;
    logic [4:0] got;

    vecs[0] = '{"idle",        2'd0, 2'd1, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'b11000};
    vecs[1] = '{"lu_rs",       2'd2, 2'd0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'b00010};
    vecs[2] = '{"after_lu",    2'd2, 2'd0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'b11000};
    vecs[3] = '{"lu_rt",       2'd0, 2'd1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'b00010};
    vecs[4] = '{"rs_unused",   2'd2, 2'd0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'b11000};
    vecs[5] = '{"no_wb",       2'd2, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'b11000};
    vecs[6] = '{"rd_differs",  2'd1, 2'd0, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'b11000};
    vecs[7] = '{"branch",      2'd0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b10110};
    vecs[8] = '{"branch_lu",   2'd2, 2'd0, 2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 5'b10110};
    vecs[9] = '{"alu_no_load", 2'd1, 2'd1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'b11000};

    // Reset held two cycles, then first free-running cycle.
    set_in(2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    sample(); advance();
    sample(); advance();
    set_idle(1'b0);
    sample();
    check_val("rst_stall_cnt", int'(stall_cnt), 0);
    check_val("rst_pc_write", int'(pc_write), 1);
    check_val("rst_busy", int'(busy), 0);
    advance();

    // Single-cycle RUN vectors.
    foreach (vecs[i]) begin
      set_in(vecs[i].rs, vecs[i].rt, vecs[i].urs, vecs[i].urt, vecs[i].rd, vecs[i].rw,
             vecs[i].mr, vecs[i].br, 1'b0, 1'b0);
      sample();
      got = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush};
      if (!vecs[i].ifw_care) got[3] = vecs[i].exp[3];
      checks++;
      if (got !== vecs[i].exp) begin
        errors++;
        $display("FAIL vec_%s: got %b want %b", vecs[i].name, got, vecs[i].exp);
      end
      advance();
    end
    set_idle(1'b0);
    sample();
    check_val("stall_after_table", int'(stall_cnt), 2);
    advance();

    // Saturation of the stall counter.
    for (int k = 0; k < 300; k++) begin
      set_lu(1'b0);
      sample(); advance();
    end
    set_idle(1'b0);
    sample();
    check_val("stall_saturated", int'(stall_cnt), SMAX);
    advance();

    // Interrupt with default drain.
    ack_at = -1; acks = 0;
    for (int k = 0; k < 10; k++) begin
      set_idle(k == 0);
      sample();
      if (int_ack) begin
        acks++;
        if (ack_at < 0) ack_at = k;
      end
      if (k == 3) check_val("intr_phase1", int'(int_phase), 1);
      if (k == 4) check_val("intr_phase2", int'(int_phase), 2);
      advance();
    end
    check_val("intr_ack_latency", ack_at, 5);
    check_val("intr_ack_count", acks, 1);

    // Load-use in first drain cycle; intr_req toggled while the sequence runs.
    ack_at = -1; acks = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 1) set_lu(1'b0);
      else set_idle(k == 0 || (k >= 2 && k <= 6 && k % 2 == 0));
      sample();
      if (int_ack) begin
        acks++;
        if (ack_at < 0) ack_at = k;
      end
      advance();
    end
    check_val("intr_lu_ack_latency", ack_at, 6);
    check_val("intr_toggle_ack_count", acks, 1);

    // Reset during PUSH_FLAGS aborts the sequence.
    acks = 0;
    for (int k = 0; k < 10; k++) begin
      set_idle(k == 0);
      if (k == 4) rst = 1'b1;
      sample();
      if (int_ack) acks++;
      if (k == 5) begin
        check_val("abort_phase", int'(int_phase), 0);
        check_val("abort_busy", int'(busy), 0);
      end
      advance();
    end
    check_val("abort_ack_count", acks, 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      set_in(2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
             1'($urandom), 1'($urandom), ($urandom_range(7) == 0), ($urandom_range(5) == 0),
             ($urandom_range(199) == 0));
      sample(); advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
